// File: rtl/seq_chunk_adder.sv
// Multi-cycle W-bit adder using one CHUNK-bit ripple slice per clock, LSB chunk first.
// Optional signed-overflow output is enabled with `define SEQ_CHUNK_ADDER_OVF_EN.
module seq_chunk_adder #(
    parameter int W     = 34,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         c_out
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int N  = (W + CHUNK - 1) / CHUNK;
    localparam int LW = W - (N - 1) * CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_next;
    logic [W-1:0]     a_reg, b_reg, s_next;
    logic             carry, cy, last;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Bits above W-1 in the final chunk stay zero, so the carry out of bit W-1
    // lands on sum[LW] rather than sum[CHUNK].
    always_comb begin
        last    = (idx == IW'(N - 1));
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < W; i++) begin
            if (i / CHUNK == int'(idx)) begin
                a_chunk[i % CHUNK] = a_reg[i];
                b_chunk[i % CHUNK] = b_reg[i];
            end
        end
        sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        cy     = last ? sum[LW] : sum[CHUNK];
        s_next = s;
        for (int i = 0; i < W; i++) begin
            if (i / CHUNK == int'(idx)) s_next[i] = sum[i % CHUNK];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            c_out <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= c_in;
                        idx   <= '0;
                    end
                end
                ADD: begin
                    s     <= s_next;
                    carry <= cy;
                    idx   <= last ? '0 : idx + IW'(1);
                    if (last) begin
                        c_out <= cy;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                        ovf   <= (a_reg[W-1] == b_reg[W-1]) && (s_next[W-1] != a_reg[W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomized self-checking bench for seq_chunk_adder (default 34/16 and a 16/16 instance).
// Checks ovf too when SEQ_CHUNK_ADDER_OVF_EN is defined.
module tb_seq_chunk_adder;

    localparam int W     = 34;
    localparam int CHUNK = 16;
    localparam int N     = (W + CHUNK - 1) / CHUNK;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         c_in = 1'b0;
    logic         busy, done, c_out;
    logic [W-1:0] s;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic         ovf;
`endif

    logic         start16 = 1'b0;
    logic [15:0]  a16 = '0, b16 = '0;
    logic         c_in16 = 1'b0;
    logic         busy16, done16, c_out16;
    logic [15:0]  s16;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic         ovf16;
`endif

    int compared   = 0;
    int mismatched = 0;
    int done_seen;

    always #5 clk = ~clk;

    seq_chunk_adder #(.W(W), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .s(s), .c_out(c_out)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    seq_chunk_adder #(.W(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c_in(c_in16),
        .busy(busy16), .done(done16), .s(s16), .c_out(c_out16)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full operation on the 34-bit DUT; optionally keeps re-pulsing start
    // with a=5/b=7 while busy, which must be ignored.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input bit pester);
        logic [W:0]   full;
        logic [W-1:0] exp_s;
        logic         exp_ovf;
        full    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        exp_s   = full[W-1:0];
        exp_ovf = (av[W-1] == bv[W-1]) && (exp_s[W-1] != av[W-1]);
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'(0));
        start = 1'b1; a = av; b = bv; c_in = cv;
        @(posedge clk);
        for (int cyc = 1; cyc <= N + 1; cyc++) begin
            @(negedge clk);
            checkOutput("busy", 64'(busy), 64'(1));
            checkOutput("done", 64'(done), 64'(cyc == N + 1));
            if (cyc == N + 1) begin
                checkOutput("sum", 64'(s), 64'(exp_s));
                checkOutput("c_out", 64'(c_out), 64'(full[W]));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                checkOutput("ovf", 64'(ovf), 64'(exp_ovf));
`endif
            end
            start = pester;
            a     = pester ? W'(5) : W'({$urandom(), $urandom()});
            b     = pester ? W'(7) : W'({$urandom(), $urandom()});
            c_in  = 1'($urandom());
        end
        @(negedge clk);
        checkOutput("after_busy", 64'(busy), 64'(0));
        checkOutput("after_done", 64'(done), 64'(0));
        checkOutput("hold_sum", 64'(s), 64'(exp_s));
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_s", 64'(s), 64'(0));
        checkOutput("rst_c_out", 64'(c_out), 64'(0));
        checkOutput("rst_s16", 64'(s16), 64'(0));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        checkOutput("rst_ovf", 64'(ovf), 64'(0));
`endif
        rst = 1'b0;

        applyStimulus(34'h3_FFFF_FFFF, 34'h0_0000_0001, 1'b0, 1'b0);
        applyStimulus(34'h0_0000_FFFF, 34'h0_0000_0001, 1'b0, 1'b0);
        applyStimulus(34'h0_FFFF_FFFF, 34'h0_0000_0000, 1'b1, 1'b0);
        applyStimulus(34'h1_2345_6789, 34'h0_ABCD_EF01, 1'b1, 1'b1);
        applyStimulus(34'h1_FFFF_FFFF, 34'h0_0000_0001, 1'b0, 1'b0);
        applyStimulus(34'h2_0000_0000, 34'h3_FFFF_FFFF, 1'b0, 1'b0);
        for (int k = 0; k < 24; k++)
            applyStimulus(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}),
                          1'($urandom()), bit'(k % 4 == 0));

        // Reset in the second ADD cycle: everything clears at once, no done follows.
        @(negedge clk);
        start = 1'b1; a = 34'h2_F0F0_1234; b = 34'h1_0F0F_4321; c_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy", 64'(busy), 64'(0));
        checkOutput("arst_done", 64'(done), 64'(0));
        checkOutput("arst_s", 64'(s), 64'(0));
        checkOutput("arst_c_out", 64'(c_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("no_done_after_rst", 64'(done_seen), 64'(0));
        applyStimulus(34'h3, 34'h4, 1'b0, 1'b0);

        // Single-chunk instance: done two edges after acceptance.
        for (int k = 0; k < 6; k++) begin
            logic [16:0] full16;
            @(negedge clk);
            start16 = 1'b1;
            a16     = (k == 0) ? 16'hFFFF : 16'($urandom());
            b16     = (k == 0) ? 16'h0001 : 16'($urandom());
            c_in16  = (k == 0) ? 1'b1 : 1'($urandom());
            full16  = {1'b0, a16} + {1'b0, b16} + {16'h0, c_in16};
            @(posedge clk);
            @(negedge clk);
            start16 = 1'b0; a16 = 16'($urandom()); b16 = 16'($urandom());
            checkOutput("w16_busy", 64'(busy16), 64'(1));
            checkOutput("w16_early_done", 64'(done16), 64'(0));
            @(negedge clk);
            checkOutput("w16_done", 64'(done16), 64'(1));
            checkOutput("w16_sum", 64'(s16), 64'(full16[15:0]));
            checkOutput("w16_c_out", 64'(c_out16), 64'(full16[16]));
            @(negedge clk);
            checkOutput("w16_idle", 64'(busy16), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
